// File: rtl/qrs_peak_scheduler.sv
// Purpose : Pan-Tompkins QRS decision controller; accepts/rejects candidate peaks
//           against signal/noise thresholds, owns refractory and RR timing, and
//           performs search-back when a beat is missed.
// Latency : decisions registered; an event appears one clk after the en cycle
//           that carried the qualifying sample.
// Backpressure: none; the block advances only on en_i strobes and never stalls.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   en_i                sample-rate strobe; nothing advances when low
//   peak_valid_i/amp_i  candidate peak from the peak detector
//   thr_i1_i, thr_i2_i  signal threshold and search-back threshold
//   qrs_valid_o         one-clk pulse per accepted beat
//   qrs_amp_o, qrs_sb_o amplitude / search-back flag of the last event (held)
//   rr_interval_o       ticks from previous beat to the last event (held)
//   rr_avg_o            running RR average
//   refractory_o        high while the refractory window is active
module qrs_peak_scheduler #(
    parameter int REFRACT = 40,
    parameter int RR_INIT = 200,
    parameter int DW      = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          peak_valid_i,
    input  logic [DW-1:0] peak_amp_i,
    input  logic [DW-1:0] thr_i1_i,
    input  logic [DW-1:0] thr_i2_i,
    output logic          qrs_valid_o,
    output logic [DW-1:0] qrs_amp_o,
    output logic          qrs_sb_o,
    output logic [15:0]   rr_interval_o,
    output logic [15:0]   rr_avg_o,
    output logic          refractory_o
);

    localparam logic [15:0] REFRACT_L = 16'(REFRACT);
    localparam logic [15:0] RR_INIT_L = 16'(RR_INIT);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_REFRACT = 2'd1,
        S_DETECT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   rr_cnt_q, rr_cnt_d;
    logic [15:0]   refr_cnt_q, refr_cnt_d;
    logic          cand_valid_q, cand_valid_d;
    logic [DW-1:0] cand_amp_q, cand_amp_d;
    logic [15:0]   cand_idx_q, cand_idx_d;
    logic          qrs_valid_q, qrs_valid_d;
    logic [DW-1:0] qrs_amp_q, qrs_amp_d;
    logic          qrs_sb_q, qrs_sb_d;
    logic [15:0]   rr_interval_q, rr_interval_d;
    logic [15:0]   rr_avg_q, rr_avg_d;

    // Search-back deadline ~1.625 x average; the sum cannot exceed 17 bits.
    logic [16:0] rr_limit_w;
    logic [15:0] rr_limit;
    assign rr_limit_w = {1'b0, rr_avg_q} + {2'b00, rr_avg_q[15:1]} + {4'b0000, rr_avg_q[15:3]};
    assign rr_limit   = rr_limit_w[16] ? 16'hFFFF : rr_limit_w[15:0];

    logic [15:0] rr_cnt_inc;
    assign rr_cnt_inc = (rr_cnt_q == 16'hFFFF) ? 16'hFFFF : rr_cnt_q + 16'd1;

    // Decision qualifiers; primary beats win over search-back, and a search-back
    // tick does not capture a new candidate because rr_cnt is being rebased.
    logic decide, primary, sb_hit, capture;
    assign decide  = en_i && (state_q != S_REFRACT);
    assign primary = decide && peak_valid_i && (peak_amp_i >= thr_i1_i);
    assign sb_hit  = en_i && (state_q == S_DETECT) && cand_valid_q
                     && (rr_cnt_q == rr_limit) && !primary;
    assign capture = decide && peak_valid_i && !primary && !sb_hit
                     && (peak_amp_i >= thr_i2_i)
                     && (!cand_valid_q || (peak_amp_i > cand_amp_q));

    // 7/8 old average plus 1/8 of the new interval.
    function automatic logic [15:0] avg_next(input logic [15:0] avg, input logic [15:0] rr);
        logic [16:0] s;
        s = {1'b0, avg} - {4'b0000, avg[15:3]} + {4'b0000, rr[15:3]};
        return s[15:0];
    endfunction

    always_comb begin
        state_d       = state_q;
        rr_cnt_d      = rr_cnt_q;
        refr_cnt_d    = refr_cnt_q;
        cand_valid_d  = cand_valid_q;
        cand_amp_d    = cand_amp_q;
        cand_idx_d    = cand_idx_q;
        qrs_valid_d   = 1'b0;
        qrs_amp_d     = qrs_amp_q;
        qrs_sb_d      = qrs_sb_q;
        rr_interval_d = rr_interval_q;
        rr_avg_d      = rr_avg_q;

        if (en_i) begin
            rr_cnt_d = rr_cnt_inc;

            if (state_q == S_REFRACT) begin
                if (refr_cnt_q == REFRACT_L) begin
                    state_d = S_DETECT;
                end else begin
                    refr_cnt_d = refr_cnt_q + 16'd1;
                end
            end

            if (primary) begin
                qrs_valid_d  = 1'b1;
                qrs_amp_d    = peak_amp_i;
                qrs_sb_d     = 1'b0;
                rr_cnt_d     = 16'd1;
                cand_valid_d = 1'b0;
                refr_cnt_d   = 16'd1;
                state_d      = S_REFRACT;
                if (state_q == S_DETECT) begin
                    rr_interval_d = rr_cnt_q;
                    rr_avg_d      = avg_next(rr_avg_q, rr_cnt_q);
                end else begin
                    // First beat: no previous beat to measure from.
                    rr_interval_d = 16'd0;
                end
            end else if (sb_hit) begin
                qrs_valid_d   = 1'b1;
                qrs_amp_d     = cand_amp_q;
                qrs_sb_d      = 1'b1;
                rr_interval_d = cand_idx_q;
                rr_avg_d      = avg_next(rr_avg_q, cand_idx_q);
                // Re-reference the counter to the recovered beat.
                rr_cnt_d      = rr_cnt_q - cand_idx_q + 16'd1;
                cand_valid_d  = 1'b0;
            end else if (capture) begin
                cand_valid_d = 1'b1;
                cand_amp_d   = peak_amp_i;
                cand_idx_d   = rr_cnt_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_WAIT;
            rr_cnt_q      <= 16'd0;
            refr_cnt_q    <= 16'd0;
            cand_valid_q  <= 1'b0;
            cand_amp_q    <= '0;
            cand_idx_q    <= 16'd0;
            qrs_valid_q   <= 1'b0;
            qrs_amp_q     <= '0;
            qrs_sb_q      <= 1'b0;
            rr_interval_q <= 16'd0;
            rr_avg_q      <= RR_INIT_L;
        end else begin
            state_q       <= state_d;
            rr_cnt_q      <= rr_cnt_d;
            refr_cnt_q    <= refr_cnt_d;
            cand_valid_q  <= cand_valid_d;
            cand_amp_q    <= cand_amp_d;
            cand_idx_q    <= cand_idx_d;
            qrs_valid_q   <= qrs_valid_d;
            qrs_amp_q     <= qrs_amp_d;
            qrs_sb_q      <= qrs_sb_d;
            rr_interval_q <= rr_interval_d;
            rr_avg_q      <= rr_avg_d;
        end
    end

    assign qrs_valid_o   = qrs_valid_q;
    assign qrs_amp_o     = qrs_amp_q;
    assign qrs_sb_o      = qrs_sb_q;
    assign rr_interval_o = rr_interval_q;
    assign rr_avg_o      = rr_avg_q;
    assign refractory_o  = (state_q == S_REFRACT);

endmodule

// File: tb/tb_qrs_peak_scheduler.sv
// Purpose : self-checking bench for qrs_peak_scheduler; directed scenarios plus
//           randomized traffic against a beat-level reference model.
// Latency : model outputs are applied at the clk edge after each driven sample.
// Backpressure: n/a; inputs are driven one sample per clk.
module tb_qrs_peak_scheduler;

    localparam int REFRACT = 40;
    localparam int RR_INIT = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        pv = 1'b0;
    logic [15:0] amp = 16'd0;
    logic [15:0] t1 = 16'd1000;
    logic [15:0] t2 = 16'd500;
    logic        qrs_valid;
    logic [15:0] qrs_amp;
    logic        qrs_sb;
    logic [15:0] rr_interval;
    logic [15:0] rr_avg;
    logic        refractory;

    qrs_peak_scheduler #(.REFRACT(REFRACT), .RR_INIT(RR_INIT), .DW(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .peak_valid_i (pv),
        .peak_amp_i   (amp),
        .thr_i1_i     (t1),
        .thr_i2_i     (t2),
        .qrs_valid_o  (qrs_valid),
        .qrs_amp_o    (qrs_amp),
        .qrs_sb_o     (qrs_sb),
        .rr_interval_o(rr_interval),
        .rr_avg_o     (rr_avg),
        .refractory_o (refractory)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- beat-level reference model ----------------
    // m_refr counts refractory ticks still to elapse; m_seen marks that a first
    // beat has occurred. Counters are plain integers with explicit saturation.
    int m_cnt, m_avg, m_refr, m_ca, m_ci;
    bit m_seen, m_cv;
    int o_valid, o_amp, o_sb, o_rri, o_refr;
    int exp_valid, exp_amp, exp_sb, exp_rri, exp_avg, exp_refr;

    task automatic model_reset();
        m_cnt = 0; m_avg = RR_INIT; m_refr = 0; m_seen = 0; m_cv = 0; m_ca = 0; m_ci = 0;
        o_valid = 0; o_amp = 0; o_sb = 0; o_rri = 0; o_refr = 0;
    endtask

    task automatic model_step(input bit e, input bit p, input int a);
        int lim;
        int cur;
        int th1;
        int th2;
        th1 = int'(t1);
        th2 = int'(t2);
        o_valid = 0;
        if (!e) return;
        cur   = m_cnt;
        m_cnt = (cur < 65535) ? cur + 1 : 65535;
        if (m_refr > 0) begin
            m_refr--;
        end else begin
            lim = m_avg + m_avg / 2 + m_avg / 8;
            if (lim > 65535) lim = 65535;
            if (p && a >= th1) begin
                o_valid = 1; o_amp = a; o_sb = 0;
                if (m_seen) begin
                    o_rri = cur;
                    m_avg = m_avg - m_avg / 8 + cur / 8;
                end else begin
                    o_rri = 0;
                end
                m_seen = 1; m_cnt = 1; m_cv = 0; m_refr = REFRACT;
            end else if (m_seen && m_cv && cur == lim) begin
                o_valid = 1; o_amp = m_ca; o_sb = 1; o_rri = m_ci;
                m_avg = m_avg - m_avg / 8 + m_ci / 8;
                m_cnt = (cur - m_ci + 1) % 65536;
                m_cv  = 0;
            end else if (p && a >= th2 && (!m_cv || a > m_ca)) begin
                m_cv = 1; m_ca = a; m_ci = cur;
            end
        end
        o_refr = (m_refr > 0) ? 1 : 0;
    endtask

    task automatic publish();
        exp_valid = o_valid; exp_amp = o_amp; exp_sb = o_sb;
        exp_rri = o_rri; exp_avg = m_avg; exp_refr = o_refr;
    endtask

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    int ev_cnt = 0;
    int refr_hi = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("qrs_valid", int'(qrs_valid), exp_valid);
            check("qrs_amp", int'(qrs_amp), exp_amp);
            check("qrs_sb", int'(qrs_sb), exp_sb);
            check("rr_interval", int'(rr_interval), exp_rri);
            check("rr_avg", int'(rr_avg), exp_avg);
            check("refractory", int'(refractory), exp_refr);
            if (qrs_valid) ev_cnt++;
            if (refractory) refr_hi++;
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input bit e, input bit p, input int a);
        en = e; pv = p; amp = 16'(a);
        model_step(e, p, a);
        @(posedge clk);
        publish();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1, 1'b0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; pv = 1'b0; amp = 16'd0;
        model_reset();
        @(posedge clk);
        publish();
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    // One en tick preceded by three disabled clks, two of which carry a large
    // peak that must be ignored.
    task automatic etick(input bit p, input int a);
        tick(1'b0, 1'b1, 1800);
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b1, 1800);
        tick(1'b1, p, a);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Two beats 200 ticks apart
        do_reset();
        check("rst_avg", int'(rr_avg), 200);
        check("rst_refr", int'(refractory), 0);
        ev_cnt = 0;
        idle(10);
        tick(1, 1, 1200);
        check("s1_first_rri", int'(rr_interval), 0);
        idle(199);
        tick(1, 1, 1200);
        check("s1_valid", int'(qrs_valid), 1);
        check("s1_rri", int'(rr_interval), 200);
        check("s1_avg", int'(rr_avg), 200);
        check("s1_sb", int'(qrs_sb), 0);
        check("s1_model_avg", m_avg, 200);
        idle(1);
        check("s1_events", ev_cnt, 2);
        check("s1_pulse_width", int'(qrs_valid), 0);

        // Refractory window
        do_reset();
        ev_cnt = 0; refr_hi = 0;
        tick(1, 1, 1200);
        idle(29);
        tick(1, 1, 1500);
        check("s2_ignored_amp", int'(qrs_amp), 1200);
        idle(10);
        tick(1, 1, 1200);
        check("s2_refr_len", refr_hi, 40);
        check("s2_valid41", int'(qrs_valid), 1);
        check("s2_rri41", int'(rr_interval), 41);
        idle(1);
        check("s2_events", ev_cnt, 2);

        // Search-back
        do_reset();
        tick(1, 1, 1200);
        idle(199);
        tick(1, 1, 1200);
        idle(189);
        tick(1, 1, 700);
        idle(135);
        check("s3_sb_valid", int'(qrs_valid), 1);
        check("s3_sb_flag", int'(qrs_sb), 1);
        check("s3_sb_amp", int'(qrs_amp), 700);
        check("s3_sb_rri", int'(rr_interval), 190);
        check("s3_sb_avg", int'(rr_avg), 198);
        check("s3_sb_refr", int'(refractory), 0);
        tick(1, 1, 1200);
        check("s3_rebased_rri", int'(rr_interval), 136);

        // Primary beat on the search-back deadline tick
        do_reset();
        tick(1, 1, 1200);
        idle(199);
        tick(1, 1, 1200);
        idle(99);
        tick(1, 1, 600);
        idle(224);
        ev_cnt = 0;
        tick(1, 1, 1200);
        check("s4_valid", int'(qrs_valid), 1);
        check("s4_sb", int'(qrs_sb), 0);
        check("s4_rri", int'(rr_interval), 325);
        check("s4_amp", int'(qrs_amp), 1200);
        idle(400);
        check("s4_events", ev_cnt, 1);

        // Sparse en strobe
        do_reset();
        ev_cnt = 0; refr_hi = 0;
        repeat (5) etick(0, 0);
        etick(1, 1200);
        repeat (99) etick(0, 0);
        etick(1, 1200);
        check("s5_rri", int'(rr_interval), 100);
        check("s5_refr_clks", refr_hi, 160);
        tick(0, 0, 0);
        check("s5_events", ev_cnt, 2);

        // Reset mid-refractory and mid-candidate
        do_reset();
        tick(1, 1, 1200);
        idle(20);
        do_reset();
        check("s6_refr", int'(refractory), 0);
        check("s6_amp", int'(qrs_amp), 0);
        check("s6_avg", int'(rr_avg), 200);
        check("s6_valid", int'(qrs_valid), 0);
        tick(1, 1, 700);
        idle(5);
        do_reset();
        idle(3);
        tick(1, 1, 1200);
        check("s6_first_rri", int'(rr_interval), 0);
        check("s6_first_amp", int'(qrs_amp), 1200);
        idle(199);
        tick(1, 1, 1200);
        idle(99);
        tick(1, 1, 700);
        idle(10);
        do_reset();
        ev_cnt = 0;
        idle(400);
        check("s6_no_sb", ev_cnt, 0);

        // Randomized traffic
        do_reset();
        for (int blk = 0; blk < 10; blk++) begin
            t1 = 16'($urandom_range(800, 1200));
            t2 = t1 >> 1;
            for (int c = 0; c < 2000; c++) begin
                if ($urandom_range(0, 4999) == 0) begin
                    do_reset();
                end else begin
                    bit e;
                    bit p;
                    int a;
                    int r;
                    e = ($urandom_range(0, 3) != 0);
                    p = ($urandom_range(0, 99) == 0);
                    r = $urandom_range(0, 9);
                    if (r < 4)      a = $urandom_range(int'(t1), int'(t1) + 500);
                    else if (r < 8) a = $urandom_range(int'(t2), int'(t1) - 1);
                    else            a = $urandom_range(0, int'(t2) - 1);
                    tick(e, p, a);
                end
            end
        end

        tick(0, 0, 0);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
